// File: rtl/overlay_tile_reader_if.sv
// Video-side and RAM-side signals of the overlay scan-out reader.
// The slave modport is the reader itself; the master drives counters and returns RAM data.
interface overlay_tile_reader_if;
    logic        i_pix;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [11:0] chram_addr;
    logic [7:0]  chmap_data_out;
    logic [11:0] chrom_addr;
    logic [7:0]  chrom_data_out;
    logic        a;
    logic        a_box;

    modport master (
        output i_pix, hcnt, vcnt, chmap_data_out, chrom_data_out,
        input  chram_addr, chrom_addr, a, a_box
    );

    modport slave (
        input  i_pix, hcnt, vcnt, chmap_data_out, chrom_data_out,
        output chram_addr, chrom_addr, a, a_box
    );
endinterface

// File: rtl/overlay_tile_reader.sv
// Overlay scan-out: walks character RAM and font ROM in raster order and emits a
// per-pixel alpha bit plus an aligned in-box flag, four pixel steps after the counters.
module overlay_tile_reader #(
    parameter int COLS   = 36,
    parameter int ROWS   = 10,
    parameter int CELL_H = 10
) (
    input  logic                 i_clk,
    input  logic                 reset,
    overlay_tile_reader_if.slave bus
);
    localparam int               ROW_W     = $clog2(ROWS + 1);
    localparam logic [3:0]       LINE_LAST = 4'(CELL_H - 1);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS);
    localparam logic [11:0]      ROW_STEP  = 12'(COLS);
    localparam logic [9:0]       H_END     = 10'(8 * COLS);
    localparam logic [9:0]       V_END     = 10'(CELL_H * ROWS);

    logic [9:0]       vcnt_r;
    logic [3:0]       line;
    logic [ROW_W-1:0] row;
    logic [11:0]      row_base;
    logic             in_box;

    logic [2:0] s1_col, s2_col, s3_col;
    logic [3:0] s1_line;
    logic       s1_box, s2_box, s3_box;
    logic       s2_blank, s3_blank;

    // Row tracking runs every clock; a change of vcnt marks a new line, no divider needed.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            vcnt_r   <= '0;
            line     <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            vcnt_r <= bus.vcnt;
            if (bus.vcnt != vcnt_r) begin
                if (bus.vcnt == '0) begin
                    line     <= '0;
                    row      <= '0;
                    row_base <= '0;
                end else if (line == LINE_LAST) begin
                    line <= '0;
                    if (row != ROW_MAX) begin
                        row      <= row + ROW_W'(1);
                        row_base <= row_base + ROW_STEP;
                    end
                end else begin
                    line <= line + 4'd1;
                end
            end
        end
    end

    always_comb begin
        in_box = (bus.hcnt < H_END) && (bus.vcnt < V_END);
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            bus.chram_addr <= '0;
            bus.chrom_addr <= '0;
            bus.a          <= 1'b0;
            bus.a_box      <= 1'b0;
            s1_col         <= '0;
            s1_line        <= '0;
            s1_box         <= 1'b0;
            s2_col         <= '0;
            s2_blank       <= 1'b0;
            s2_box         <= 1'b0;
            s3_col         <= '0;
            s3_blank       <= 1'b0;
            s3_box         <= 1'b0;
        end else if (bus.i_pix) begin
            bus.chram_addr <= row_base + {5'b0, bus.hcnt[9:3]};
            s1_col         <= bus.hcnt[2:0];
            s1_line        <= line;
            s1_box         <= in_box;

            bus.chrom_addr <= {1'b0, bus.chmap_data_out, s1_line[2:0]};
            s2_col         <= s1_col;
            s2_blank       <= (s1_line >= 4'd8);
            s2_box         <= s1_box;

            // Font ROM data settles during this stage; only control bits move.
            s3_col   <= s2_col;
            s3_blank <= s2_blank;
            s3_box   <= s2_box;

            bus.a     <= s3_box & ~s3_blank & bus.chrom_data_out[3'd7 - s3_col];
            bus.a_box <= s3_box;
        end
    end
endmodule

// File: tb/tb_overlay_tile_reader.sv
// Randomised raster scan of the overlay reader against a cell/glyph lookup model
// with behavioural character RAM and font ROM.
module tb_overlay_tile_reader;
    localparam int COLS   = 36;
    localparam int ROWS   = 10;
    localparam int CELL_H = 10;

    logic i_clk = 1'b0;
    logic reset = 1'b1;

    overlay_tile_reader_if bus();

    overlay_tile_reader #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CELL_H (CELL_H)
    ) dut (
        .i_clk (i_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] chram [0:2047];
    logic [7:0] font  [0:4095];

    always @(posedge i_clk) begin
        bus.chmap_data_out <= chram[bus.chram_addr[10:0]];
        bus.chrom_data_out <= font[bus.chrom_addr];
    end

    typedef struct {
        logic a;
        logic box;
        bit   chk_a;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   prev_idx    = 0;
    bit   model_ok    = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int row_of(int v);
        return (v / CELL_H < ROWS) ? v / CELL_H : ROWS;
    endfunction

    function automatic int cell_idx(int v, int h);
        return (row_of(v) * COLS + h / 8) % 4096;
    endfunction

    function automatic logic [7:0] char_at(int v, int h);
        return chram[cell_idx(v, h) % 2048];
    endfunction

    function automatic logic pix_exp(int v, int h);
        logic [7:0] fb;
        int ln;
        ln = v % CELL_H;
        fb = font[char_at(v, h) * 8 + ln % 8];
        return fb[7 - h % 8];
    endfunction

    task automatic seed_pipe();
        exp_t z;
        z.a = 1'b0; z.box = 1'b0; z.chk_a = 1'b1;
        sb.delete();
        repeat (3) sb.push_back(z);
    endtask

    // The glyph at a cell edge depends on RAM read timing relative to step spacing,
    // so 'a' is scored only where the neighbouring steps fetch the same glyph.
    task automatic step(input int v, input int h, input int gap, input bit has_next,
                        input int next_h, input bit addr_chk);
        exp_t e;
        exp_t o;
        bit inb, blank, forced;
        logic [7:0] ch;
        inb    = (h < COLS * 8) && (v < ROWS * CELL_H);
        blank  = (v % CELL_H) >= 8;
        forced = !inb || blank;
        ch     = char_at(v, h);
        e.box  = inb;
        e.a    = (forced || !model_ok) ? 1'b0 : pix_exp(v, h);
        e.chk_a = forced || (model_ok && has_next && chram[prev_idx % 2048] == ch
                             && char_at(v, next_h) == ch);
        bus.hcnt  = 10'(h);
        bus.i_pix = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_pix = 1'b0;
        if (addr_chk && model_ok)
            check_val("chram_addr", 32'(bus.chram_addr), 32'(cell_idx(v, h)));
        prev_idx = cell_idx(v, h);
        sb.push_back(e);
        if (sb.size() >= 4) begin
            o = sb.pop_front();
            check_val("a_box", 32'(bus.a_box), 32'(o.box));
            if (o.chk_a) check_val("a", 32'(bus.a), 32'(o.a));
        end
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic burst(input int v, input int h0, input int count, input int gap, input bit addr_chk);
        for (int i = 0; i < count; i++)
            step(v, h0 + i, gap, i < count - 1, h0 + i + 1, addr_chk && i == 0);
    endtask

    task automatic new_line(input int v);
        bus.vcnt = 10'(v);
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) chram[i] = 8'($urandom);
        for (int i = 0; i < 4096; i++) font[i]  = 8'($urandom);
        chram[0]   = 8'h41;
        chram[1]   = 8'h41;
        chram[331] = 8'h20;
        font[8'h41 * 8]     = 8'h81;
        font[8'h41 * 8 + 1] = 8'hFF;
        for (int k = 0; k < 8; k++) font[8'h96 * 8 + k] = 8'h5A ^ 8'(k);

        bus.i_pix = 1'b0;
        bus.hcnt  = '0;
        bus.vcnt  = '0;
        reset     = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        reset = 1'b0;
        seed_pipe();
        prev_idx = 0;

        for (int v = 0; v <= 105; v++) begin
            new_line(v);
            if (v == 0) begin
                burst(0, 0, 9, 0, 1'b1);
                burst(0, 0, 9, 2, 1'b0);
            end
            if (v == 8 || v == 9) burst(v, 0, 16, 0, 1'b1);
            if (v == 50) chram[331] = 8'h96;
            if (v >= 90 && v < 100) burst(v, 50, 20, $urandom_range(0, 2), 1'b1);
            if (v == 99) burst(99, 280, 16, 1, 1'b0);
            if (v == 100) burst(100, 280, 16, 0, 1'b1);
            repeat (2) burst(v, $urandom_range(0, 320), $urandom_range(3, 12), $urandom_range(0, 2), 1'b1);
        end

        // Reset mid-line: the row model is meaningless until vcnt passes through 0 again.
        model_ok = 1'b0;
        new_line(50);
        burst(50, 0, 8, 0, 1'b0);
        reset = 1'b1;
        @(posedge i_clk);
        #1;
        check_val("rst_a", 32'(bus.a), 32'(0));
        check_val("rst_a_box", 32'(bus.a_box), 32'(0));
        reset    = 1'b0;
        bus.vcnt = '0;
        seed_pipe();
        prev_idx = 0;
        model_ok = 1'b1;
        for (int v = 0; v <= 25; v++) begin
            new_line(v);
            burst(v, $urandom_range(0, 280), 6, $urandom_range(0, 2), 1'b1);
        end
        repeat (3) step(0, 1000, 0, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/overlay_tile_reader.md
# overlay_tile_reader

Scan-out engine for the cassette status overlay. Walks the character index RAM and font ROM in raster order from the video counters and produces a per-pixel alpha bit plus a delayed in-box flag for the overlay mixer. It is the read-side counterpart of the progress-bar/tape-wheel writer, which updates the same character index RAM through the other port.

## Interface
- COLS, 36, character columns in the overlay box
- ROWS, 10, character rows in the overlay box
- CELL_H, 10, pixel lines per character cell; glyphs are 8x8, so lines 8..CELL_H-1 are blank
- Clock and reset: reset reset, synchronous, active-high; clock i_clk.
- i_clk  in  1  system clock; both RAMs are clocked on it
- reset  in  1  synchronous, active-high
- i_pix  in  1  pixel enable; every pipeline stage advances only when high
- hcnt  in  10  horizontal pixel counter, 0 = first visible pixel
- vcnt  in  10  vertical line counter, 0 = first visible line
- chram_addr  out  12  character index RAM read address, registered
- chmap_data_out  in  8  character index RAM data, 1-cycle synchronous read
- chrom_addr  out  12  font ROM address {1'b0, char[7:0], line[2:0]}, registered
- chrom_data_out  in  8  font ROM row byte, 1-cycle synchronous read, bit 7 = leftmost pixel
- a  out  1  glyph pixel set and inside box, registered
- a_box  out  1  in-box flag aligned with a

## Operation
- Row tracking (every i_clk, independent of i_pix): register vcnt into vcnt_r. When vcnt != vcnt_r:
  - if vcnt == 0: line <= 0, row <= 0, row_base <= 0
  - else if line == CELL_H-1: line <= 0, row <= row+1, row_base <= row_base+COLS
  - else: line <= line+1
  - vcnt == 0 takes priority over wrap.
- No divider. row/row_base saturate once row == ROWS; in_box is already false beyond that point.
- in_box = (hcnt < 8*COLS) && (vcnt < CELL_H*ROWS), evaluated on the stage-1 inputs.
- Pipeline, one step per i_pix:
  - S1: chram_addr <= row_base + hcnt[9:3]. Latch hcnt[2:0], line, and in_box.
  - S2: chrom_addr <= {1'b0, chmap_data_out, line[2:0]}. Forward col, blank = (line >= 8), and in_box.
  - S3: wait stage; ROM data returns. Forward col, blank, and in_box.
  - S4: a <= in_box & ~blank & chrom_data_out[7-col]; a_box <= in_box.
- Address arithmetic is 12-bit and wraps modulo 4096. Only [10:0] is used by the 2 KB RAMs.
- Outside the box, addresses are still generated (harmless reads), but a is forced to 0.
- The block never writes. Writer updates land on the next fetch of that cell, with no tearing guarantee within a frame.

## Timing
- Reset values: chram_addr = 0, chrom_addr = 0, a = 0, a_box = 0, line = 0, row = 0, row_base = 0, vcnt_r = 0, all pipeline valid/box bits = 0.
- Latency: hcnt/vcnt presented with i_pix high at step n appear on a/a_box at step n+4. With i_pix tied high this is 4 i_clk cycles. The mixer offsets hcnt by 4 or accepts the shift.
- i_pix may be sparse, minimum one idle-or-active cycle between steps. RAM outputs are held because addresses only change on i_pix, so data is valid at the next step.
- Row counters update on the i_clk after vcnt changes. vcnt must be stable for at least 2 i_clk cycles before the first i_pix of a line.
- Reset mid-line: the pipeline is flushed to 0. The first valid a appears 4 steps after reset deasserts, and row tracking resyncs at the next vcnt == 0.
- Simultaneous vcnt change and i_pix: S1 uses the old row_base for that step only; the line's first pixel is h=0, which precedes the change by blanking.

## Test plan
- Char RAM addr 0 = 0x41, font 0x41 line0 = 0x81, vcnt=0, hcnt 0..7 with i_pix high -> a = 1,0,0,0,0,0,0,1 starting 4 cycles after hcnt=0, with a_box = 1 throughout.
- vcnt stepped 0..25 -> at line 10 chram_addr = 36 + hcnt/8, at line 20 = 72 + hcnt/8, and line wraps to 0 at vcnt 10 and 20. At vcnt 8/9 a = 0 even with a font byte of 0xFF.
- hcnt = 288 or vcnt = 100 with font 0xFF -> a = 0, a_box = 0. hcnt = 287, vcnt = 99 -> a_box = 1.
- i_pix pulsing 1-in-3 -> same a sequence as the continuous case, delayed by 4 steps, not 4 cycles.
- Write addr 331 = 0x96 mid-frame while scanning -> row 9 col 7 shows the 0x96 glyph on the next scan of that cell.
- Assert reset with vcnt = 50 mid-line -> a = 0 and a_box = 0 next cycle. After the vcnt returns to 0, vcnt 10 yields chram_addr base 36.
